// File: rtl/vertex_xform_pipe_if.sv
// Vertex stream in/out plus matrix load port for vertex_xform_pipe.
// slave = the transform block, master = whoever drives it.
interface vertex_xform_pipe_if #(
    parameter int WIDTH = 32
);
    logic [3:0][WIDTH-1:0] pos;
    logic                  valid_in;
    logic                  ready_out;
    logic                  obj_done_in;
    logic                  mat_we_in;
    logic [3:0]            mat_addr_in;
    logic [WIDTH-1:0]      mat_data_in;
    logic                  mat_commit_in;
    logic                  commit_pending_out;
    logic [3:0][WIDTH-1:0] new_pos;
    logic                  valid_out;
    logic                  ready_in;
    logic                  obj_done_out;

    modport slave (
        input  pos, valid_in, obj_done_in, mat_we_in, mat_addr_in, mat_data_in,
               mat_commit_in, ready_in,
        output ready_out, commit_pending_out, new_pos, valid_out, obj_done_out
    );

    modport master (
        output pos, valid_in, obj_done_in, mat_we_in, mat_addr_in, mat_data_in,
               mat_commit_in, ready_in,
        input  ready_out, commit_pending_out, new_pos, valid_out, obj_done_out
    );
endinterface

// File: rtl/vertex_xform_pipe.sv
// 4x4 fixed-point matrix x vertex transform, valid/ready pipelined, with a
// shadow matrix bank that is swapped in only between objects.

module vertex_xform_row #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_i,
    input  logic [3:0][WIDTH-1:0] m_i,
    input  logic [3:0][WIDTH-1:0] v_i,
    output logic [WIDTH-1:0]      res_o
);
    localparam int PW = 2 * WIDTH;
    localparam int P1 = PW + 1;
    localparam int SW = 2 * WIDTH + 2;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod_d [4];
    logic signed [PW-1:0] prod_q [4];
    logic signed [P1-1:0] psum_d [2];
    logic signed [P1-1:0] psum_q [2];
    logic signed [SW-1:0] sum_d, shr_d;
    logic [WIDTH-1:0]     res_d, res_q;

    always_comb begin
        for (int c = 0; c < 4; c++)
            prod_d[c] = PW'($signed(m_i[c])) * PW'($signed(v_i[c]));
        psum_d[0] = P1'(prod_q[0]) + P1'(prod_q[1]);
        psum_d[1] = P1'(prod_q[2]) + P1'(prod_q[3]);
        sum_d     = SW'(psum_q[0]) + SW'(psum_q[1]);
        shr_d     = sum_d >>> FRAC;
        if (shr_d > SAT_MAX)      res_d = {1'b0, {(WIDTH-1){1'b1}}};
        else if (shr_d < SAT_MIN) res_d = {1'b1, {(WIDTH-1){1'b0}}};
        else                      res_d = shr_d[WIDTH-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < 4; c++) prod_q[c] <= '0;
            psum_q[0] <= '0;
            psum_q[1] <= '0;
            res_q     <= '0;
        end else if (en_i) begin
            for (int c = 0; c < 4; c++) prod_q[c] <= prod_d[c];
            psum_q[0] <= psum_d[0];
            psum_q[1] <= psum_d[1];
            res_q     <= res_d;
        end
    end

    assign res_o = res_q;
endmodule

module vertex_xform_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    vertex_xform_pipe_if.slave  bus
);
    localparam int STAGES = 3;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    logic [15:0][WIDTH-1:0] active_q, active_d, shadow_q, shadow_d;
    logic                   commit_pending_q, commit_pending_d;
    logic                   boundary_q, boundary_d;
    logic [STAGES:0]        vld_pipe_q, vld_pipe_d;
    logic [STAGES:0]        od_pipe_q, od_pipe_d;
    logic [3:0][WIDTH-1:0]  pos_q, pos_d, vin, row_res, new_pos_w;
    logic                   stall, apply, fire;

    assign stall = vld_pipe_q[STAGES] & ~bus.ready_in;
    // Copy waits out a stall so a captured-but-unmultiplied vertex never sees the new bank.
    assign apply = commit_pending_q & boundary_q & ~stall;
    assign bus.ready_out = ~stall & ~(commit_pending_q & boundary_q);
    assign fire = bus.valid_in & bus.ready_out;

    always_comb begin
        shadow_d = shadow_q;
        if (bus.mat_we_in) shadow_d[bus.mat_addr_in] = bus.mat_data_in;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        if (apply) begin
            active_d         = shadow_q;
            commit_pending_d = 1'b0;
        end else if (bus.mat_commit_in) begin
            commit_pending_d = 1'b1;
        end
        boundary_d = boundary_q;
        if (fire) boundary_d = bus.obj_done_in;
        vld_pipe_d = vld_pipe_q;
        od_pipe_d  = od_pipe_q;
        pos_d      = pos_q;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:0], fire};
            od_pipe_d  = {od_pipe_q[STAGES-1:0], fire & bus.obj_done_in};
            pos_d      = bus.pos;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 16; i++) begin
                active_q[i] <= (i % 5 == 0) ? ONE : '0;
                shadow_q[i] <= (i % 5 == 0) ? ONE : '0;
            end
            commit_pending_q <= 1'b0;
            boundary_q       <= 1'b1;
            vld_pipe_q       <= '0;
            od_pipe_q        <= '0;
            pos_q            <= '0;
        end else begin
            active_q         <= active_d;
            shadow_q         <= shadow_d;
            commit_pending_q <= commit_pending_d;
            boundary_q       <= boundary_d;
            vld_pipe_q       <= vld_pipe_d;
            od_pipe_q        <= od_pipe_d;
            pos_q            <= pos_d;
        end
    end

    // Column c of the matrix multiplies x,y,z,w in that order; pos[3] is x.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            vin[c]           = pos_q[3-c];
            new_pos_w[3-c]   = row_res[c];
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        vertex_xform_row #(.WIDTH(WIDTH), .FRAC(FRAC)) u_row (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .en_i     (~stall),
            .m_i      (active_q[r*4 +: 4]),
            .v_i      (vin),
            .res_o    (row_res[r])
        );
    end

    assign bus.new_pos            = new_pos_w;
    assign bus.valid_out          = vld_pipe_q[STAGES];
    assign bus.obj_done_out       = od_pipe_q[STAGES];
    assign bus.commit_pending_out = commit_pending_q;
endmodule

// File: tb/tb_vertex_xform_pipe.sv
// Directed bench for vertex_xform_pipe: identity, commit timing, saturation,
// backpressure and mid-stream asynchronous reset.
module tb_vertex_xform_pipe;
    typedef logic [3:0][31:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    vec_t out_q[$];
    logic od_q[$];
    bit   stab_chk = 1'b0;
    logic prev_stall = 1'b0;
    vec_t prev_pos;
    logic prev_od;

    vertex_xform_pipe_if #(.WIDTH(32)) bus ();

    vertex_xform_pipe #(.WIDTH(32), .FRAC(16)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stab_chk && prev_stall) begin
            n_checks++;
            if (bus.new_pos !== prev_pos || bus.valid_out !== 1'b1 || bus.obj_done_out !== prev_od) begin
                n_fail++;
                $display("FAIL stall_hold: got pos=%h v=%b od=%b, want pos=%h v=1 od=%b",
                         bus.new_pos, bus.valid_out, bus.obj_done_out, prev_pos, prev_od);
            end
        end
        prev_stall = bus.valid_out & ~bus.ready_in;
        prev_pos   = bus.new_pos;
        prev_od    = bus.obj_done_out;
        if (rst_n && bus.valid_out && bus.ready_in) begin
            out_q.push_back(bus.new_pos);
            od_q.push_back(bus.obj_done_out);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input logic [31:0] w);
        return {x, y, z, w};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input vec_t p, input logic od);
        int t = 0;
        bus.pos = p; bus.obj_done_in = od; bus.valid_in = 1'b1;
        @(negedge clk);
        while (!bus.ready_out && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: ready_out stayed 0 for %0d cycles, want 1", t);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0; bus.obj_done_in = 1'b0;
    endtask

    task automatic write_mat(input logic [3:0] a, input logic [31:0] d, input logic c);
        bus.mat_we_in = 1'b1; bus.mat_addr_in = a; bus.mat_data_in = d; bus.mat_commit_in = c;
        @(posedge clk); #1;
        bus.mat_we_in = 1'b0; bus.mat_commit_in = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_q.size() < n && t < 60) begin @(posedge clk); t++; end
        #1;
        if (out_q.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL wait_out: got %0d outputs, want %0d", out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.new_pos !== '0) begin n_fail++; $display("FAIL rst_pos: got %h want 0", bus.new_pos); end
        n_checks++; if (bus.obj_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_od: got %b want 0", bus.obj_done_out); end
        n_checks++; if (bus.commit_pending_out !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", bus.commit_pending_out); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.ready_out); end
    endtask

    task automatic test_identity();
        vec_t v = mk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        out_q.delete(); od_q.delete();
        send(v, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL id_ready1: got %b want 1", bus.ready_out); end
        @(posedge clk); #1;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL id_early: valid_out got %b want 0", bus.valid_out); end
        @(posedge clk); #1;
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL id_latency: valid_out got %b want 1", bus.valid_out); end
        n_checks++; if (bus.new_pos !== v) begin n_fail++; $display("FAIL id_pos: got %h want %h", bus.new_pos, v); end
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL id_ready2: got %b want 1", bus.ready_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_translation_commit();
        vec_t v = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        vec_t e = mk(32'h000B_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        out_q.delete(); od_q.delete();
        write_mat(4'd3, 32'h000A_0000, 1'b1);
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL tr_apply_ready: got %b want 0", bus.ready_out); end
        n_checks++; if (bus.commit_pending_out !== 1'b1) begin n_fail++; $display("FAIL tr_pend: got %b want 1", bus.commit_pending_out); end
        @(posedge clk); #1;
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL tr_ready_back: got %b want 1", bus.ready_out); end
        n_checks++; if (bus.commit_pending_out !== 1'b0) begin n_fail++; $display("FAIL tr_pend_clr: got %b want 0", bus.commit_pending_out); end
        send(v, 1'b1);
        wait_out(1);
        if (out_q.size() > 0) begin
            n_checks++; if (out_q[0] !== e) begin n_fail++; $display("FAIL tr_pos: got %h want %h", out_q[0], e); end
        end
    endtask

    task automatic test_deferred_commit();
        vec_t v1 = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        vec_t v2 = mk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        vec_t e[3];
        e[0] = mk(32'h000B_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        e[1] = mk(32'h000B_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        e[2] = mk(32'h000B_0000, 32'h0004_0000, 32'h0003_0000, 32'h0001_0000);
        out_q.delete(); od_q.delete();
        send(v1, 1'b0);
        write_mat(4'd5, 32'h0002_0000, 1'b1);
        n_checks++; if (bus.commit_pending_out !== 1'b1) begin n_fail++; $display("FAIL df_pend: got %b want 1", bus.commit_pending_out); end
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL df_ready_mid: got %b want 1", bus.ready_out); end
        send(v2, 1'b1);
        n_checks++; if (bus.commit_pending_out !== 1'b1) begin n_fail++; $display("FAIL df_pend_copy: got %b want 1", bus.commit_pending_out); end
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL df_apply_ready: got %b want 0", bus.ready_out); end
        send(v2, 1'b1);
        n_checks++; if (bus.commit_pending_out !== 1'b0) begin n_fail++; $display("FAIL df_pend_clr: got %b want 0", bus.commit_pending_out); end
        wait_out(3);
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() > i) begin
                n_checks++; if (out_q[i] !== e[i]) begin n_fail++; $display("FAIL df_pos%0d: got %h want %h", i, out_q[i], e[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        vec_t e[3];
        e[0] = mk(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0);
        e[1] = mk(32'h8000_0000, 32'h0, 32'h0, 32'h0);
        e[2] = mk(32'hFFFF_8001, 32'h0, 32'h0, 32'h0);
        out_q.delete(); od_q.delete();
        write_mat(4'd0, 32'h7FFF_0000, 1'b1);
        send(mk(32'h0002_0000, 32'h0, 32'h0, 32'h0), 1'b1);
        send(mk(32'hFFFE_0000, 32'h0, 32'h0, 32'h0), 1'b1);
        send(mk(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0), 1'b1);
        wait_out(3);
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() > i) begin
                n_checks++; if (out_q[i] !== e[i]) begin n_fail++; $display("FAIL sat%0d: got %h want %h", i, out_q[i], e[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t v[8];
        bit   done = 1'b0;
        for (int i = 0; i < 8; i++)
            v[i] = mk((i << 16) | 32'h123, (i + 10) << 16, 32'hFFFF_0000 - i, 32'h0001_0000);
        write_mat(4'd0, 32'h0001_0000, 1'b0);
        write_mat(4'd3, 32'h0, 1'b0);
        write_mat(4'd5, 32'h0001_0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        out_q.delete(); od_q.delete();
        stab_chk = 1'b1;
        fork
            begin
                int k = 0;
                while (!done) begin
                    bus.ready_in = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                    @(posedge clk); #1;
                end
                bus.ready_in = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send(v[i], i == 7);
                done = 1'b1;
            end
        join
        wait_out(8);
        stab_chk = 1'b0;
        n_checks++; if (out_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (out_q.size() > i) begin
                n_checks++; if (out_q[i] !== v[i]) begin n_fail++; $display("FAIL bp_pos%0d: got %h want %h", i, out_q[i], v[i]); end
                n_checks++; if (od_q[i] !== (i == 7)) begin n_fail++; $display("FAIL bp_od%0d: got %b want %b", i, od_q[i], (i == 7)); end
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t v = mk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        write_mat(4'd10, 32'h0003_0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send(v, 1'b0);
        write_mat(4'd0, 32'h0005_0000, 1'b1);
        send(v, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.new_pos !== '0) begin n_fail++; $display("FAIL ar_pos: got %h want 0", bus.new_pos); end
        n_checks++; if (bus.commit_pending_out !== 1'b0) begin n_fail++; $display("FAIL ar_pend: got %b want 0", bus.commit_pending_out); end
        n_checks++; if (bus.obj_done_out !== 1'b0) begin n_fail++; $display("FAIL ar_od: got %b want 0", bus.obj_done_out); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_q.delete(); od_q.delete();
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", bus.ready_out); end
        send(v, 1'b1);
        wait_out(1);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (out_q.size() != 1) begin n_fail++; $display("FAIL ar_count: got %0d want 1", out_q.size()); end
        if (out_q.size() > 0) begin
            n_checks++; if (out_q[0] !== v) begin n_fail++; $display("FAIL ar_identity: got %h want %h", out_q[0], v); end
        end
    endtask

    initial begin
        bus.pos = '0; bus.valid_in = 1'b0; bus.obj_done_in = 1'b0;
        bus.mat_we_in = 1'b0; bus.mat_addr_in = '0; bus.mat_data_in = '0;
        bus.mat_commit_in = 1'b0; bus.ready_in = 1'b1;
        test_reset();
        test_identity();
        test_translation_commit();
        test_deferred_commit();
        test_saturation();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
